fifo_wr_arbiter: RTL and testbench

Round-robin, frame-locking arbiter that shares the async FIFO's single write port among NUM_REQ requesters in the write clock domain.
- Grants one requester at a time and holds the grant until that requester's last word, so frames never interleave.
- Drives the FIFO write-increment and write-data, and honours the FIFO full flag.
- A stall watchdog reclaims the port if a granted requester goes silent mid-frame.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e     : arbiter state encoding (idle / locked on a frame)
//   gnt_w()         : grant-index width, $clog2 with a floor of 1
//   DefaultStallMax : default mid-frame idle tolerance
package fifo_arb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultStallMax = 15;

    function automatic int unsigned gnt_w(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
//   vld_i   : request vector
//   ptr_i   : highest-priority position this round
//   found_o : at least one request is set
//   idx_o   : first set request at or after ptr_i, modulo N
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] vld_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        int unsigned j;
        logic [W-1:0] cand;
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        cand    = '0;
        // Scan farthest-first so the candidate nearest ptr_i is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            j    = (32'(ptr_i) + unsigned'(k)) % N;
            cand = W'(j);
            if (vld_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, frame-locking arbiter for the async FIFO write port.
//   clk_i       : write-domain clock
//   rst_ni      : asynchronous active-low reset
//   req_vld_i   : per-requester valid
//   req_last_i  : per-requester last word of frame (qualified by valid)
//   req_data_i  : packed data, requester i at [i*DSize +: DSize]
//   req_rdy_o   : per-requester ready; transfer on vld & rdy
//   full_i      : FIFO full flag
//   w_inc_o     : FIFO write increment
//   w_data_o    : FIFO write data (zero when no write)
//   gnt_id_o    : current grant holder
//   busy_o      : a grant is held
//   stall_err_o : one-cycle pulse when the watchdog reclaims the port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned DSize    = 16,
    parameter int unsigned StallMax = DefaultStallMax,
    localparam int unsigned GntW    = gnt_w(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_vld_i,
    input  logic [NumReq-1:0]       req_last_i,
    input  logic [NumReq*DSize-1:0] req_data_i,
    output logic [NumReq-1:0]       req_rdy_o,
    input  logic                    full_i,
    output logic                    w_inc_o,
    output logic [DSize-1:0]        w_data_o,
    output logic [GntW-1:0]         gnt_id_o,
    output logic                    busy_o,
    output logic                    stall_err_o
);

    arb_state_e      state_q, state_d;
    logic [GntW-1:0] gnt_q, gnt_d;
    logic [GntW-1:0] rr_q, rr_d;
    logic [7:0]      stall_cnt_q, stall_cnt_d;
    logic            stall_err_q, stall_err_d;

    logic            pick_found;
    logic [GntW-1:0] pick_idx;
    logic            gnt_vld;
    logic            gnt_last;
    logic [GntW-1:0] gnt_next;

    rr_pick #(
        .N (NumReq),
        .W (GntW)
    ) u_rr_pick (
        .vld_i   (req_vld_i),
        .ptr_i   (rr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign gnt_vld  = req_vld_i[gnt_q];
    assign gnt_last = req_last_i[gnt_q];
    // Pointer moves past the holder so it loses priority to everyone else next round.
    assign gnt_next = (gnt_q == GntW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = 1'b0;
        req_rdy_o   = '0;
        w_inc_o     = 1'b0;
        w_data_o    = '0;

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d       = pick_idx;
                    stall_cnt_d = '0;
                    state_d     = StLock;
                end
            end
            StLock: begin
                req_rdy_o[gnt_q] = ~full_i;
                w_inc_o          = gnt_vld & ~full_i;
                if (w_inc_o) begin
                    w_data_o    = req_data_i[gnt_q*DSize +: DSize];
                    stall_cnt_d = '0;
                    if (gnt_last) begin
                        state_d = StIdle;
                        rr_d    = gnt_next;
                    end
                end else if (!gnt_vld) begin
                    // Valid-but-full cycles hold the count: backpressure is not a stall.
                    if (({1'b0, stall_cnt_q} + 9'd1) >= 9'(StallMax)) begin
                        state_d     = StIdle;
                        rr_d        = gnt_next;
                        stall_cnt_d = '0;
                        stall_err_d = 1'b1;
                    end else begin
                        stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            rr_q        <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign gnt_id_o    = gnt_q;
    assign busy_o      = (state_q == StLock);
    assign stall_err_o = stall_err_q;

    a_rdy_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(req_rdy_o));
    a_winc_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_inc_o |-> busy_o);
    a_gnt_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (busy_o && $past(busy_o)) |-> $stable(gnt_id_o));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int SMAX = 15;
    localparam int GW   = 2;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } word_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_vld, req_last, req_rdy;
    logic [N*DW-1:0] req_data;
    logic            full, w_inc, busy, stall_err;
    logic [DW-1:0]   w_data;
    logic [GW-1:0]   gnt_id;

    word_t  pend[N][$];   // words still to be presented by each requester
    word_t  exp_q[N][$];  // scoreboard: words each requester must see written, in order
    int     vld_pct;
    int     n_chk, n_fail;
    logic [N-1:0] xfer_s;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NumReq   (N),
        .DSize    (DW),
        .StallMax (SMAX)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_vld_i   (req_vld),
        .req_last_i  (req_last),
        .req_data_i  (req_data),
        .req_rdy_o   (req_rdy),
        .full_i      (full),
        .w_inc_o     (w_inc),
        .w_data_o    (w_data),
        .gnt_id_o    (gnt_id),
        .busy_o      (busy),
        .stall_err_o (stall_err)
    );

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference arbitration rule: first valid at or after ptr, modulo N.
    function automatic int pick(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += pend[i].size();
        return s;
    endfunction

    task automatic push_word(int i, logic last, logic [DW-1:0] data);
        word_t w;
        w.last = last;
        w.data = data;
        pend[i].push_back(w);
        exp_q[i].push_back(w);
    endtask

    task automatic send_frame(int i, int len, logic [DW-1:0] base);
        for (int k = 0; k < len; k++) push_word(i, (k == len - 1), base + DW'(k));
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0 && $urandom_range(0, 99) < vld_pct) begin
                req_vld[i]             = 1'b1;
                req_last[i]            = pend[i][0].last;
                req_data[i*DW +: DW]   = pend[i][0].data;
            end else begin
                req_vld[i]             = 1'b0;
                req_last[i]            = 1'($urandom_range(0, 1));
                req_data[i*DW +: DW]   = DW'($urandom);
            end
        end
    endtask

    // half(): mid-cycle sample point; adv(): clock edge, retire transferred words, re-drive.
    task automatic half();
        @(negedge clk);
        xfer_s = req_vld & req_rdy;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (xfer_s[i]) void'(pend[i].pop_front());
        drive();
    endtask

    task automatic step();
        half();
        adv();
    endtask

    task automatic drain();
        int guard = 0;
        vld_pct = 100;
        full    = 1'b0;
        while (pending() != 0 && guard < 2000) begin
            step();
            guard++;
        end
        check("drain_done", pending(), 0);
        step();
        step();
    endtask

    // Monitor / scoreboard: rule-level model of grant, release and data ordering.
    logic [N-1:0]  prev_vld;
    logic          prev_busy, exp_idle, exp_stall;
    logic [GW-1:0] prev_gnt;
    int            rr_m, idle_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld  = '0;
            prev_busy = 1'b0;
            exp_idle  = 1'b0;
            exp_stall = 1'b0;
            prev_gnt  = '0;
            rr_m      = 0;
            idle_m    = 0;
        end else begin
            logic [N-1:0] rdy_exp;
            logic         winc_exp;
            logic         have;
            word_t        w;
            rdy_exp = '0;
            if (busy && !full) rdy_exp[gnt_id] = 1'b1;
            check("req_rdy", 32'(req_rdy), 32'(rdy_exp));
            winc_exp = busy & req_vld[gnt_id] & ~full;
            check("w_inc", 32'(w_inc), 32'(winc_exp));
            if (!w_inc) check("w_data_idle", 32'(w_data), 0);
            check("stall_err", 32'(stall_err), 32'(exp_stall));
            if (exp_idle || exp_stall) check("release_idle", 32'(busy), 0);
            if (busy && prev_busy) check("gnt_stable", 32'(gnt_id), 32'(prev_gnt));
            if (!prev_busy) check("arb_bubble", 32'(busy), 32'(|prev_vld));
            if (busy && !prev_busy) begin
                check("rr_grant", 32'(gnt_id), pick(prev_vld, rr_m));
                idle_m = 0;
            end
            exp_idle  = 1'b0;
            exp_stall = 1'b0;
            if (w_inc) begin
                have = (exp_q[gnt_id].size() != 0);
                check("write_expected", 32'(have), 1);
                if (have) begin
                    w = exp_q[gnt_id].pop_front();
                    check("w_data", 32'(w_data), 32'(w.data));
                    if (w.last) begin
                        exp_idle = 1'b1;
                        rr_m     = (int'(gnt_id) + 1) % N;
                    end
                end
                idle_m = 0;
            end else if (busy && !req_vld[gnt_id]) begin
                idle_m++;
                if (idle_m == SMAX) begin
                    exp_stall = 1'b1;
                    idle_m    = 0;
                    rr_m      = (int'(gnt_id) + 1) % N;
                end
            end
            prev_busy = busy;
            prev_vld  = req_vld;
            prev_gnt  = gnt_id;
        end
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        full     = 1'b0;
        req_vld  = '0;
        req_last = '0;
        req_data = '0;
        vld_pct  = 100;
        xfer_s   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(gnt_id), 0);
        check("rst_winc", 32'(w_inc), 0);
        check("rst_rdy", 32'(req_rdy), 0);
        check("rst_stall", 32'(stall_err), 0);
        check("rst_wdata", 32'(w_data), 0);
        rst_n = 1'b1;

        // Round robin: everyone valid with single-word frames.
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) send_frame(i, 1, DW'(16'h1000 * i + r));
        drive();
        for (int f = 0; f < 2 * N; f++) begin
            half(); check("rr_bubble", 32'(busy), 0); adv();
            half(); check("rr_order", 32'(gnt_id), f % N); check("rr_write", 32'(w_inc), 1); adv();
        end

        // Frame lock: req0 4-word frame while req2 waits.
        send_frame(0, 4, 16'h0C00);
        send_frame(2, 1, 16'h2C00);
        drive();
        half(); check("lock_idle", 32'(busy), 0); adv();
        for (int k = 0; k < 4; k++) begin
            half();
            check("lock_gnt", 32'(gnt_id), 0);
            check("lock_data", 32'(w_data), 32'(16'h0C00 + k));
            check("lock_rdy2", 32'(req_rdy[2]), 0);
            adv();
        end
        half(); check("lock_bubble", 32'(busy), 0); check("lock_rdy2_idle", 32'(req_rdy[2]), 0); adv();
        half(); check("lock_next_gnt", 32'(gnt_id), 2); check("lock_next_winc", 32'(w_inc), 1); adv();

        // Single requester, 3-word frame.
        send_frame(1, 3, 16'h00A1);
        drive();
        half(); check("single_idle", 32'(busy), 0); adv();
        for (int k = 0; k < 3; k++) begin
            half();
            check("single_gnt", 32'(gnt_id), 1);
            check("single_winc", 32'(w_inc), 1);
            check("single_data", 32'(w_data), 32'(16'h00A1 + k));
            adv();
        end
        half(); check("single_busy_drop", 32'(busy), 0); adv();

        // FULL for 5 cycles covering the LAST beat.
        send_frame(1, 3, 16'h0B00);
        drive();
        half(); adv();
        half(); check("full_w0", 32'(w_data), 32'(16'h0B00)); adv();
        half(); check("full_w1", 32'(w_data), 32'(16'h0B01)); adv();
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            half();
            check("full_no_winc", 32'(w_inc), 0);
            check("full_no_rdy", 32'(req_rdy), 0);
            check("full_busy", 32'(busy), 1);
            check("full_no_stall", 32'(stall_err), 0);
            adv();
        end
        full = 1'b0;
        half(); check("full_last_winc", 32'(w_inc), 1); check("full_last_data", 32'(w_data), 32'(16'h0B02)); adv();
        half(); check("full_release", 32'(busy), 0); adv();

        // Watchdog: req3 sends one word without LAST, then goes silent; req0 waits.
        push_word(3, 1'b0, 16'h3D01);
        send_frame(0, 2, 16'h0D00);
        drive();
        half(); adv();
        half(); check("wd_gnt", 32'(gnt_id), 3); check("wd_write", 32'(w_inc), 1); adv();
        for (int k = 1; k <= SMAX; k++) begin
            half(); check("wd_hold", 32'(busy), 1); check("wd_no_err", 32'(stall_err), 0); adv();
        end
        half(); check("wd_err", 32'(stall_err), 1); check("wd_release", 32'(busy), 0); adv();
        half(); check("wd_next_gnt", 32'(gnt_id), 0); check("wd_next_busy", 32'(busy), 1); adv();
        drain();

        // Asynchronous reset in the middle of a req2 frame.
        send_frame(2, 4, 16'h2E00);
        drive();
        half(); adv();
        half(); adv();
        half(); adv();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_winc", 32'(w_inc), 0);
        check("arst_rdy", 32'(req_rdy), 0);
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            exp_q[i].delete();
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(3, 1, 16'h3E00);
        send_frame(0, 1, 16'h0E00);
        drive();
        half(); check("arst_idle", 32'(busy), 0); adv();
        half(); check("arst_rr_gnt", 32'(gnt_id), 0); check("arst_rr_winc", 32'(w_inc), 1); adv();
        drain();

        // Randomised traffic with random FULL and requester gaps.
        vld_pct = 80;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, N - 1);
                if (pend[r].size() < 8) send_frame(r, $urandom_range(1, 5), DW'($urandom));
            end
            step();
            full = ($urandom_range(0, 4) == 0);
        end
        drain();
        for (int i = 0; i < N; i++) check("exp_empty", exp_q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, required completion before time limit");
        $fatal(1, "timeout");
    end

endmodule
